icosoc_ctrl_master: RTL
=======================

# icosoc_ctrl_master

Bus initiator for the icosoc peripheral control bus. Accepts single read/write commands on a valid/ready command port, drives the `ctrl_*` strobes to a peripheral responder such as the GPIO module, waits for `ctrl_done`, and returns read data and status on a valid/ready response port. A timeout prevents a hung or absent responder from stalling the requester. Sits between a command source (debug bridge, DMA sequencer) and the per-peripheral control bus.

## Interface

- `TIMEOUT_CYCLES`, default 255: maximum number of cycles strobes are held without `ctrl_done`. Legal range is ≥1.
- `clk`  in  1  clock.
- `resetn`  in  1  reset: one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high at a rising edge.
- `cmd_wstrb`  in  4  byte write strobes. Nonzero means write; 0 means read.
- `cmd_addr`  in  16  peripheral register address.
- `cmd_wdat`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_rdat`  out  32  read data. 0 for writes; 0xFFFF_FFFF on timeout.
- `rsp_err`  out  1  1 means the command timed out.
- `ctrl_wr`  out  4  write strobes to the responder.
- `ctrl_rd`  out  1  read strobe to the responder.
- `ctrl_addr`  out  16  address to the responder.
- `ctrl_wdat`  out  32  write data to the responder.
- `ctrl_rdat`  in  32  responder read data. Valid only in the cycle `ctrl_done` is high.
- `ctrl_done`  in  1  responder completion pulse (one cycle).

## Operation

- All outputs are registered.
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdat`=0, `ctrl_wr`=0, `ctrl_rd`=0, `ctrl_addr`=0, `ctrl_wdat`=0, timer=0, state=IDLE.
- Timer width is `$clog2(TIMEOUT_CYCLES+1)`.

**State machine**

- **IDLE**
  - `cmd_ready`=1. It rises on the first edge after reset release and after each response handshake.
  - On accept:
    - latch `ctrl_addr` and `ctrl_wdat`;
    - for a write, set `ctrl_wr`=`cmd_wstrb`; for a read, set `ctrl_rd`=1;
    - clear `cmd_ready` and the timer;
    - go to BUS.
- **BUS**
  - Strobes, address and data are held constant. The timer increments each cycle.
  - If `ctrl_done` is sampled high:
    - clear the strobes;
    - set `rsp_rdat` = `ctrl_rdat` (read) or 0 (write), and `rsp_err`=0;
    - set `rsp_valid`=1 and go to RESP.
  - Else, if timer == `TIMEOUT_CYCLES`-1:
    - clear the strobes;
    - set `rsp_rdat`=0xFFFF_FFFF and `rsp_err`=1;
    - set `rsp_valid`=1 and go to RESP.
  - If `ctrl_done` and timeout coincide, `ctrl_done` wins: normal completion.
- **RESP**
  - `rsp_valid`, `rsp_rdat` and `rsp_err` are held stable until `rsp_ready`.
  - On handshake: clear `rsp_valid`, set `cmd_ready`=1, go to IDLE.

**Rules**

- Only one outstanding command at a time. No command is accepted in BUS or RESP.
- `ctrl_done` outside BUS is ignored.
- `ctrl_rdat` is never sampled except in the BUS cycle where `ctrl_done`=1.
- `ctrl_addr` and `ctrl_wdat` keep their last values after completion. Only the strobes return to 0.
- Reset asserted mid-operation forces all outputs to their reset values immediately. The in-flight command is dropped and no response is produced.

## Timing

- Command accepted at edge N, so strobes are visible from cycle N+1.
- With a responder whose `ctrl_done` is registered one cycle after the strobe (GPIO-style):
  - `ctrl_done` is high in cycle N+2 and sampled at edge N+2;
  - strobes are high for exactly 2 cycles;
  - `rsp_valid` is high from cycle N+3.
- The responder ignores the second strobe cycle because its `ctrl_done` is high then. The master relies on this and performs no extra gating.
- Timeout: strobes are high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` rises.
- Minimum command-to-command period with `rsp_ready` tied high: 4 cycles (accept, 2 × BUS, RESP). The next accept is 1 cycle after the response handshake.

## Test plan

1. **Write.** Write `cmd_wstrb`=4'hF, addr 0x0004, wdat 0x0000_00FF to a GPIO-style responder model.
   - `ctrl_wr`=4'hF with addr 0x0004 for exactly 2 cycles.
   - `rsp_valid` 3 cycles after accept, `rsp_err`=0, `rsp_rdat`=0.
2. **Read.** Read addr 0x0000; model returns 0xA5A5_0001 only in its done cycle (X otherwise).
   - `ctrl_rd` pulses for 2 cycles.
   - `rsp_rdat`=0xA5A5_0001, `rsp_err`=0.
3. **Timeout.** `TIMEOUT_CYCLES`=8, responder never asserts done; issue a read.
   - `ctrl_rd` high exactly 8 cycles.
   - `rsp_err`=1, `rsp_rdat`=0xFFFF_FFFF.
   - A following normal write completes correctly.
4. **Coincident done.** `TIMEOUT_CYCLES`=8, responder asserts done in the 8th strobe cycle with data 0x1234_5678.
   - `rsp_err`=0, `rsp_rdat`=0x1234_5678.
5. **Backpressure.** Hold `rsp_ready` low 5 cycles; keep a second command valid; pulse spurious `ctrl_done` during RESP.
   - Response stays stable and `cmd_ready` stays 0.
   - The second command is accepted exactly 1 cycle after the handshake.
   - The spurious done has no effect.
6. **Reset mid-operation.** Assert `resetn` low during BUS.
   - All outputs go to 0 without waiting for a clock edge.
   - After release, `cmd_ready`=1 after the first edge and no `rsp_valid` appears.

Source files
------------

// File: rtl/icosoc_ctrl_master_if.sv
// Command, response and peripheral control-bus signals of the icosoc control master.
// The master modport is the initiator's view; slave is the environment's view.
interface icosoc_ctrl_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_wstrb;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    input  cmd_valid, cmd_wstrb, cmd_addr, cmd_wdat, rsp_ready, ctrl_rdat, ctrl_done,
    output cmd_ready, rsp_valid, rsp_rdat, rsp_err, ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat
  );

  modport slave (
    output cmd_valid, cmd_wstrb, cmd_addr, cmd_wdat, rsp_ready, ctrl_rdat, ctrl_done,
    input  cmd_ready, rsp_valid, rsp_rdat, rsp_err, ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat
  );
endinterface

// File: rtl/icosoc_ctrl_master.sv
// Single-outstanding initiator for the icosoc peripheral control bus: issues one
// read/write, waits for ctrl_done or a timeout, and returns data/status.
module icosoc_ctrl_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  resetn,
  icosoc_ctrl_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdat_q, rsp_rdat_d;
  logic          rsp_err_q, rsp_err_d;
  logic [3:0]    ctrl_wr_q, ctrl_wr_d;
  logic          ctrl_rd_q, ctrl_rd_d;
  logic [15:0]   ctrl_addr_q, ctrl_addr_d;
  logic [31:0]   ctrl_wdat_q, ctrl_wdat_d;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      timer_q     <= {TW{1'b0}};
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdat_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      ctrl_wr_q   <= 4'h0;
      ctrl_rd_q   <= 1'b0;
      ctrl_addr_q <= 16'h0000;
      ctrl_wdat_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdat_q  <= rsp_rdat_d;
      rsp_err_q   <= rsp_err_d;
      ctrl_wr_q   <= ctrl_wr_d;
      ctrl_rd_q   <= ctrl_rd_d;
      ctrl_addr_q <= ctrl_addr_d;
      ctrl_wdat_q <= ctrl_wdat_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdat_d  = rsp_rdat_q;
    rsp_err_d   = rsp_err_q;
    ctrl_wr_d   = ctrl_wr_q;
    ctrl_rd_d   = ctrl_rd_q;
    ctrl_addr_d = ctrl_addr_q;
    ctrl_wdat_d = ctrl_wdat_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          ctrl_addr_d = bus.cmd_addr;
          ctrl_wdat_d = bus.cmd_wdat;
          if (bus.cmd_wstrb != 4'h0) begin
            ctrl_wr_d = bus.cmd_wstrb;
            ctrl_rd_d = 1'b0;
          end else begin
            ctrl_wr_d = 4'h0;
            ctrl_rd_d = 1'b1;
          end
          cmd_ready_d = 1'b0;
          timer_d     = {TW{1'b0}};
          state_d     = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS: begin
        timer_d = timer_q + TW'(1);
        // ctrl_done takes priority over a timeout in the same cycle
        if (bus.ctrl_done) begin
          ctrl_wr_d   = 4'h0;
          ctrl_rd_d   = 1'b0;
          rsp_rdat_d  = ctrl_rd_q ? bus.ctrl_rdat : 32'h0000_0000;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          ctrl_wr_d   = 4'h0;
          ctrl_rd_d   = 1'b0;
          rsp_rdat_d  = 32'hFFFF_FFFF;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_BUS;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        ctrl_wr_d   = 4'h0;
        ctrl_rd_d   = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdat  = rsp_rdat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.ctrl_wr   = ctrl_wr_q;
  assign bus.ctrl_rd   = ctrl_rd_q;
  assign bus.ctrl_addr = ctrl_addr_q;
  assign bus.ctrl_wdat = ctrl_wdat_q;

endmodule
